decode_rob: RTL and testbench
=============================

// Module: decode_rob
// PURPOSE
//  16-entry in-order reorder buffer beside the decode/rename stage. Allocates a ROB index and
//  FID-tagged destination per renamed instruction and captures out-of-order writebacks. Serves
//  two asynchronous operand read ports to rename (value + ready), and retires the head entry in
//  order onto the commit bus that updates the register file and the RAT.
// PARAMETERS
//  ROB_W   4   ROB index width; depth = 2**ROB_W = 16 (must match rename's 4-bit rob tags)
//  FID_W   8   fetch/instruction id width
//  DATA_W  32  result width
// PORTS
//  clk             in   1       clock
//  resetn          in   1       asynchronous active-low reset
//  snoop_hit       in   1       pipeline hold: blocks allocation and commit this cycle
//  bco_valid       in   1       branch-correction flush: discard all uncommitted entries
//  alloc_en        in   1       allocate tail entry (honoured only when alloc_ready)
//  alloc_fid       in   FID_W   fid of allocating instruction
//  alloc_dst       in   5       architectural destination (0 = no write)
//  alloc_ready     out  1       free entry available and no hold/flush
//  alloc_rob       out  ROB_W   index the next allocation receives (= tail)
//  rob_addra       in   ROB_W   read port A index (rename src0)
//  rob_dina        out  DATA_W  port A value
//  rob_dina_ready  out  1       port A entry done (value valid)
//  rob_addrb       in   ROB_W   read port B index (rename src1)
//  rob_dinb        out  DATA_W  port B value
//  rob_dinb_ready  out  1       port B entry done
//  wb_en           in   1       execution writeback
//  wb_rob          in   ROB_W   writeback index
//  wb_data         in   DATA_W  writeback result
//  rob_cm_en       out  1       commit strobe (registered)
//  rob_cm_addr     out  5       committed destination
//  rob_cm_fid      out  FID_W   committed fid
//  rob_cm_data     out  DATA_W  committed value
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all valid/done=0; rob_cm_en=0, rob_cm_addr=0, rob_cm_fid=0,
//    rob_cm_data=0; alloc_rob=0; alloc_ready=1 once resetn released.
//  - Per entry state: valid, done, fid, dst, data. head/tail wrap modulo 16; count is ROB_W+1 bits.
//  - alloc_ready = (count != 16) & ~snoop_hit & ~bco_valid. Full ROB blocks alloc even if a
//    commit happens the same cycle (no same-cycle slot reuse).
//  - Allocate (alloc_en & alloc_ready): entry[tail] <= {valid=1, done=0, fid, dst}; tail++.
//  - Writeback (wb_en & entry[wb_rob].valid): data <= wb_data, done <= 1. wb to invalid entry ignored.
//  - Read ports combinational: ready = valid & done, value = data. Same-cycle bypass: if
//    wb_en & wb_rob==addr & entry valid -> value = wb_data, ready = 1. Invalid entry -> ready=0, value=0.
//  - Commit: if entry[head].valid & done & ~snoop_hit & ~bco_valid, at the clock edge load
//    rob_cm_* from head, clear valid, head++; rob_cm_en high exactly one cycle per retired entry,
//    else rob_cm_en=0 (addr/fid/data hold). Max one commit per cycle. dst=0 still commits.
//  - Latency: wb sampled at edge E0 -> rob_cm_en visible after E1 (if at head). Alloc->wb->commit
//    minimum 3 edges.
//  - Simultaneous alloc+commit: count unchanged, both pointers advance. Alloc+wb to same index in
//    one cycle: wb ignored (entry not yet valid).
//  - bco_valid: at edge all valid<=0, head=tail (tail snaps to head), count=0; dominates alloc,
//    wb and commit that cycle; rob_cm_en=0 next cycle.
//  - Async reset mid-operation clears all state immediately irrespective of clk.
// STRUCTURE
//  - Shared header decode_defines.vh: ROB_W, FID_W, DATA_W, REG_W=5 constants.
//  - Sub-module decode_rob_ram: 16xDATA_W storage, 1 sync write + 3 async read (A, B, head);
//    control bits (valid/done/fid/dst) and pointers stay as flops in decode_rob.
// TESTING
//  1 Reset: after resetn rises -> alloc_ready=1, alloc_rob=0, rob_cm_en=0, dina_ready=0.
//  2 Alloc fid=0x11 dst=5 (rob 0); wb rob0 data=0xDEADBEEF -> dina (addra=0) ready=1 same cycle
//    via bypass; next cycle rob_cm_en=1, addr=5, fid=0x11, data=0xDEADBEEF.
//  3 Out-of-order: alloc rob0..2, wb 2,1,0 on consecutive cycles -> commits 0,1,2 on 3 consecutive
//    cycles starting one cycle after wb of rob0.
//  4 Fill 16 entries -> alloc_ready=0 at count=16; wb+commit head -> alloc_ready=1 next cycle,
//    alloc_rob wraps 15->0.
//  5 Six entries in flight, pulse bco_valid with wb_en+alloc_en -> no commit, count=0,
//    alloc_rob=old head, all read ports ready=0.
//  6 snoop_hit for 3 cycles with done head -> rob_cm_en stays 0, alloc_ready=0; commit on release.

Source files
------------

// File: rtl/decode_rob_pkg.sv
// Shared widths and the commit-bus payload for the decode-stage reorder buffer.
package decode_rob_pkg;

  localparam int unsigned ROB_W     = 4;
  localparam int unsigned ROB_DEPTH = 1 << ROB_W;
  localparam int unsigned FID_W     = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned CNT_W     = ROB_W + 1;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [FID_W-1:0]  fid;
    logic [DATA_W-1:0] data;
  } rob_commit_t;

endpackage

// File: rtl/decode_rob_ram.sv
// Result storage for the ROB: one synchronous write port (writeback) and three
// asynchronous read ports (rename operand A, operand B, commit head).
module decode_rob_ram
  import decode_rob_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ROB_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ROB_W-1:0]  raddr_a_i,
  input  logic [ROB_W-1:0]  raddr_b_i,
  input  logic [ROB_W-1:0]  raddr_h_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] rdata_h_o
);

  logic [DATA_W-1:0] mem_q [ROB_DEPTH];

  // Contents are only observed through valid entries, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
  assign rdata_h_o = mem_q[raddr_h_i];

endmodule

// File: rtl/decode_rob.sv
// 16-entry in-order reorder buffer: allocates at rename, captures out-of-order
// writebacks, serves two operand read ports and retires the head onto the commit bus.
module decode_rob
  import decode_rob_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              snoop_hit,
  input  logic              bco_valid,
  input  logic              alloc_en,
  input  logic [FID_W-1:0]  alloc_fid,
  input  logic [REG_W-1:0]  alloc_dst,
  output logic              alloc_ready,
  output logic [ROB_W-1:0]  alloc_rob,
  input  logic [ROB_W-1:0]  rob_addra,
  output logic [DATA_W-1:0] rob_dina,
  output logic              rob_dina_ready,
  input  logic [ROB_W-1:0]  rob_addrb,
  output logic [DATA_W-1:0] rob_dinb,
  output logic              rob_dinb_ready,
  input  logic              wb_en,
  input  logic [ROB_W-1:0]  wb_rob,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rob_cm_en,
  output logic [REG_W-1:0]  rob_cm_addr,
  output logic [FID_W-1:0]  rob_cm_fid,
  output logic [DATA_W-1:0] rob_cm_data
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [FID_W-1:0]     fid_q [ROB_DEPTH];
  logic [FID_W-1:0]     fid_d [ROB_DEPTH];
  logic [REG_W-1:0]     dst_q [ROB_DEPTH];
  logic [REG_W-1:0]     dst_d [ROB_DEPTH];
  logic [ROB_W-1:0]     head_q, head_d;
  logic [ROB_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 cm_en_q, cm_en_d;
  rob_commit_t          cm_q, cm_d;

  logic                 alloc_fire;
  logic                 wb_fire;
  logic                 commit_fire;
  logic                 byp_a, byp_b;
  logic [DATA_W-1:0]    ram_a, ram_b, ram_h;

  // A full ROB refuses allocation even when the head retires in the same cycle.
  assign alloc_ready = (count_q != FULL_CNT) & ~snoop_hit & ~bco_valid;
  assign alloc_rob   = tail_q;
  assign alloc_fire  = alloc_en & alloc_ready;
  assign wb_fire     = wb_en & valid_q[wb_rob] & ~bco_valid;
  assign commit_fire = valid_q[head_q] & done_q[head_q] & ~snoop_hit & ~bco_valid;

  decode_rob_ram u_ram (
    .clk       (clk),
    .we_i      (wb_fire),
    .waddr_i   (wb_rob),
    .wdata_i   (wb_data),
    .raddr_a_i (rob_addra),
    .raddr_b_i (rob_addrb),
    .raddr_h_i (head_q),
    .rdata_a_o (ram_a),
    .rdata_b_o (ram_b),
    .rdata_h_o (ram_h)
  );

  // Operand read ports with same-cycle writeback bypass; invalid entries read as zero.
  always_comb begin
    byp_a          = wb_en & (wb_rob == rob_addra) & valid_q[rob_addra];
    byp_b          = wb_en & (wb_rob == rob_addrb) & valid_q[rob_addrb];
    rob_dina_ready = valid_q[rob_addra] & (done_q[rob_addra] | byp_a);
    rob_dinb_ready = valid_q[rob_addrb] & (done_q[rob_addrb] | byp_b);
    rob_dina       = '0;
    rob_dinb       = '0;
    if (byp_a) begin
      rob_dina = wb_data;
    end else if (valid_q[rob_addra]) begin
      rob_dina = ram_a;
    end
    if (byp_b) begin
      rob_dinb = wb_data;
    end else if (valid_q[rob_addrb]) begin
      rob_dinb = ram_b;
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    fid_d   = fid_q;
    dst_d   = dst_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cm_en_d = 1'b0;
    cm_d    = cm_q;
    if (bco_valid) begin
      // Flush discards every uncommitted entry; the tail collapses onto the head.
      valid_d = '0;
      tail_d  = head_q;
      count_d = '0;
    end else begin
      if (wb_fire) begin
        done_d[wb_rob] = 1'b1;
      end
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + ROB_W'(1);
        cm_en_d         = 1'b1;
        cm_d.addr       = dst_q[head_q];
        cm_d.fid        = fid_q[head_q];
        cm_d.data       = ram_h;
      end
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        fid_d[tail_q]   = alloc_fid;
        dst_d[tail_q]   = alloc_dst;
        tail_d          = tail_q + ROB_W'(1);
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cm_en_q <= 1'b0;
      cm_q    <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        fid_q[i] <= '0;
        dst_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cm_en_q <= cm_en_d;
      cm_q    <= cm_d;
      fid_q   <= fid_d;
      dst_q   <= dst_d;
    end
  end

  assign rob_cm_en   = cm_en_q;
  assign rob_cm_addr = cm_q.addr;
  assign rob_cm_fid  = cm_q.fid;
  assign rob_cm_data = cm_q.data;

endmodule

// File: tb/tb_decode_rob.sv
// Bench for decode_rob: directed scenarios plus randomized traffic against a
// queue-based model of the in-flight instruction window.
module tb_decode_rob;
  import decode_rob_pkg::*;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              snoop_hit = 1'b0;
  logic              bco_valid = 1'b0;
  logic              alloc_en = 1'b0;
  logic [FID_W-1:0]  alloc_fid = '0;
  logic [REG_W-1:0]  alloc_dst = '0;
  logic              alloc_ready;
  logic [ROB_W-1:0]  alloc_rob;
  logic [ROB_W-1:0]  rob_addra = '0;
  logic [DATA_W-1:0] rob_dina;
  logic              rob_dina_ready;
  logic [ROB_W-1:0]  rob_addrb = '0;
  logic [DATA_W-1:0] rob_dinb;
  logic              rob_dinb_ready;
  logic              wb_en = 1'b0;
  logic [ROB_W-1:0]  wb_rob = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              rob_cm_en;
  logic [REG_W-1:0]  rob_cm_addr;
  logic [FID_W-1:0]  rob_cm_fid;
  logic [DATA_W-1:0] rob_cm_data;

  always #5 clk = ~clk;

  decode_rob dut (
    .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
    .alloc_en(alloc_en), .alloc_fid(alloc_fid), .alloc_dst(alloc_dst),
    .alloc_ready(alloc_ready), .alloc_rob(alloc_rob),
    .rob_addra(rob_addra), .rob_dina(rob_dina), .rob_dina_ready(rob_dina_ready),
    .rob_addrb(rob_addrb), .rob_dinb(rob_dinb), .rob_dinb_ready(rob_dinb_ready),
    .wb_en(wb_en), .wb_rob(wb_rob), .wb_data(wb_data),
    .rob_cm_en(rob_cm_en), .rob_cm_addr(rob_cm_addr), .rob_cm_fid(rob_cm_fid),
    .rob_cm_data(rob_cm_data)
  );

  typedef struct {
    int          idx;
    logic [7:0]  fid;
    logic [4:0]  dst;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  bit          m_cm_en;
  logic [4:0]  m_cm_addr;
  logic [7:0]  m_cm_fid;
  logic [31:0] m_cm_data;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    m_tail    = 0;
    m_cm_en   = 1'b0;
    m_cm_addr = '0;
    m_cm_fid  = '0;
    m_cm_data = '0;
  endfunction

  function automatic int m_head();
    return (m_tail - int'(q.size()) + 16) % 16;
  endfunction

  // Expected read-port result; known=0 when the entry is pending (value unspecified).
  task automatic exp_read(input logic [3:0] addr, output bit rdy, output logic [31:0] val,
                          output bit known);
    rdy = 1'b0; val = '0; known = 1'b1;
    foreach (q[i]) begin
      if (q[i].idx == int'(addr)) begin
        if (wb_en && wb_rob == addr) begin
          rdy = 1'b1; val = wb_data;
        end else if (q[i].done) begin
          rdy = 1'b1; val = q[i].data;
        end else begin
          known = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    bit r; bit k; logic [31:0] v;
    chk("alloc_ready", 32'(alloc_ready), 32'(q.size() != 16 && !snoop_hit && !bco_valid));
    chk("alloc_rob", 32'(alloc_rob), 32'(m_tail));
    exp_read(rob_addra, r, v, k);
    chk("dina_ready", 32'(rob_dina_ready), 32'(r));
    if (k) chk("dina", rob_dina, v);
    exp_read(rob_addrb, r, v, k);
    chk("dinb_ready", 32'(rob_dinb_ready), 32'(r));
    if (k) chk("dinb", rob_dinb, v);
    chk("cm_en", 32'(rob_cm_en), 32'(m_cm_en));
    chk("cm_addr", 32'(rob_cm_addr), 32'(m_cm_addr));
    chk("cm_fid", 32'(rob_cm_fid), 32'(m_cm_fid));
    chk("cm_data", rob_cm_data, m_cm_data);
  endtask

  task automatic model_step();
    int sz; bit commit; bit aok;
    if (!resetn) begin
      m_reset();
      return;
    end
    sz = q.size();
    if (bco_valid) begin
      m_tail  = m_head();
      q.delete();
      m_cm_en = 1'b0;
      return;
    end
    aok    = (sz != 16) && !snoop_hit;
    commit = (sz > 0) && q[0].done && !snoop_hit;
    m_cm_en = commit;
    if (commit) begin
      m_cm_addr = q[0].dst;
      m_cm_fid  = q[0].fid;
      m_cm_data = q[0].data;
    end
    if (wb_en) begin
      foreach (q[i]) begin
        if (q[i].idx == int'(wb_rob)) begin
          q[i].done = 1'b1;
          q[i].data = wb_data;
        end
      end
    end
    if (commit) void'(q.pop_front());
    if (alloc_en && aok) begin
      q.push_back('{idx: m_tail, fid: alloc_fid, dst: alloc_dst, done: 1'b0, data: 32'h0});
      m_tail = (m_tail + 1) % 16;
    end
  endtask

  // One clock: check outputs, advance model at the edge, return at the next negedge.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    snoop_hit = 1'b0;
    bco_valid = 1'b0;
    alloc_en  = 1'b0;
    wb_en     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    #2 resetn = 1'b0;
    #1 m_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic do_alloc(input logic [7:0] fid, input logic [4:0] dst);
    idle(); alloc_en = 1'b1; alloc_fid = fid; alloc_dst = dst; tick();
  endtask

  task automatic do_wb(input logic [3:0] idx, input logic [31:0] d);
    idle(); wb_en = 1'b1; wb_rob = idx; wb_data = d; tick();
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();

    // Reset values
    #1;
    chk("t1_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("t1_alloc_rob", 32'(alloc_rob), 32'd0);
    chk("t1_cm_en", 32'(rob_cm_en), 32'd0);
    chk("t1_dina_ready", 32'(rob_dina_ready), 32'd0);

    // Single instruction with bypass and commit
    do_alloc(8'h11, 5'd5);
    idle(); wb_en = 1'b1; wb_rob = 4'd0; wb_data = 32'hDEADBEEF; rob_addra = 4'd0;
    #1;
    chk("t2_byp_ready", 32'(rob_dina_ready), 32'd1);
    chk("t2_byp_val", rob_dina, 32'hDEADBEEF);
    tick();
    idle(); tick();
    chk("t2_cm_en", 32'(rob_cm_en), 32'd1);
    chk("t2_cm_addr", 32'(rob_cm_addr), 32'd5);
    chk("t2_cm_fid", 32'(rob_cm_fid), 32'h11);
    chk("t2_cm_data", rob_cm_data, 32'hDEADBEEF);

    // Out-of-order writebacks retire in order
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(8'(8'h20 + i), 5'(i + 1));
    for (int i = 2; i >= 0; i--) do_wb(4'(i), 32'(32'h100 + i));
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      chk("t3_cm_en", 32'(rob_cm_en), 32'd1);
      chk("t3_cm_fid", 32'(rob_cm_fid), 32'(8'h20 + i));
    end
    idle(); tick();
    chk("t3_cm_idle", 32'(rob_cm_en), 32'd0);

    // Full ROB blocks allocation even during a commit
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(8'(i), 5'(i));
    #1;
    chk("t4_full_ready", 32'(alloc_ready), 32'd0);
    chk("t4_full_rob", 32'(alloc_rob), 32'd0);
    do_wb(4'd0, 32'hCAFE0000);
    idle(); alloc_en = 1'b1; alloc_fid = 8'hEE; tick();
    #1;
    chk("t4_cm_fid", 32'(rob_cm_fid), 32'd0);
    chk("t4_ready_again", 32'(alloc_ready), 32'd1);
    chk("t4_rob_wrap", 32'(alloc_rob), 32'd0);

    // Branch-correction flush with six entries in flight
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(8'(8'h40 + i), 5'(i));
    do_wb(4'd0, 32'h1);
    do_wb(4'd1, 32'h2);
    idle(); tick();
    idle(); bco_valid = 1'b1; wb_en = 1'b1; wb_rob = 4'd3; wb_data = 32'h33;
    alloc_en = 1'b1; alloc_fid = 8'h99; tick();
    idle(); rob_addra = 4'd3; rob_addrb = 4'd2;
    #1;
    chk("t5_alloc_rob", 32'(alloc_rob), 32'd2);
    chk("t5_cm_en", 32'(rob_cm_en), 32'd0);
    chk("t5_dina_ready", 32'(rob_dina_ready), 32'd0);
    chk("t5_dinb_ready", 32'(rob_dinb_ready), 32'd0);
    tick();

    // Pipeline hold stalls commit and allocation
    do_reset();
    do_alloc(8'h77, 5'd9);
    do_wb(4'd0, 32'h5A5A5A5A);
    for (int i = 0; i < 3; i++) begin
      idle(); snoop_hit = 1'b1; alloc_en = 1'b1;
      #1 chk("t6_hold_ready", 32'(alloc_ready), 32'd0);
      tick();
      chk("t6_hold_cm", 32'(rob_cm_en), 32'd0);
    end
    idle(); tick();
    chk("t6_release_cm", 32'(rob_cm_en), 32'd1);
    chk("t6_release_data", rob_cm_data, 32'h5A5A5A5A);

    // Randomized traffic, with one asynchronous reset mid-run
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      idle();
      snoop_hit = ($urandom_range(0, 9) == 0);
      bco_valid = ($urandom_range(0, 39) == 0);
      alloc_en  = ($urandom_range(0, 9) < 6);
      alloc_fid = 8'($urandom);
      alloc_dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wb_en     = ($urandom_range(0, 9) < 6);
      wb_data   = $urandom;
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
        wb_rob = 4'(q[$urandom_range(0, q.size() - 1)].idx);
      else
        wb_rob = 4'($urandom);
      rob_addra = (q.size() > 0 && $urandom_range(0, 1) == 1) ?
                  4'(q[$urandom_range(0, q.size() - 1)].idx) : 4'($urandom);
      rob_addrb = (q.size() > 0 && $urandom_range(0, 1) == 1) ? wb_rob : 4'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
